// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue path: ALU op codes and the RV64
// integer opcode, funct3 and funct7 values used by the decoder.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational translation of RV64 integer-op fields into the ALU op code,
// operand source select, word-form flag and illegal flag.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit SUPPORT_W = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       use_imm,
  output logic       is_w,
  output logic       illegal
);

  logic f7_base;
  logic f7_shamt6;

  assign f7_base   = (funct7 == F7_BASE);
  // 64-bit immediate shifts carry shamt[5] in funct7[0]
  assign f7_shamt6 = (funct7[6:1] == 6'b000000);

  always_comb begin
    alu_op  = ALU_NOP;
    use_imm = 1'b0;
    is_w    = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          F3_ADD: begin
            if (f7_base)               alu_op = ALU_ADD;
            else if (funct7 == F7_SUB) alu_op = ALU_SUB;
          end
          F3_SLL: if (f7_base) alu_op = ALU_SLL;
          F3_XOR: if (f7_base) alu_op = ALU_XOR;
          F3_SRL: if (f7_base) alu_op = ALU_SRL;
          F3_OR:  if (f7_base) alu_op = ALU_OR;
          F3_AND: if (f7_base) alu_op = ALU_AND;
          default: alu_op = ALU_NOP;
        endcase
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        case (funct3)
          F3_ADD: alu_op = ALU_ADD;
          F3_SLL: if (f7_shamt6) alu_op = ALU_SLL;
          F3_XOR: alu_op = ALU_XOR;
          F3_SRL: if (f7_shamt6) alu_op = ALU_SRL;
          F3_OR:  alu_op = ALU_OR;
          F3_AND: alu_op = ALU_AND;
          default: alu_op = ALU_NOP;
        endcase
      end
      OPC_OP_32: begin
        is_w = 1'b1;
        if (SUPPORT_W) begin
          case (funct3)
            F3_ADD: begin
              if (f7_base)               alu_op = ALU_ADD;
              else if (funct7 == F7_SUB) alu_op = ALU_SUB;
            end
            F3_SLL: if (f7_base) alu_op = ALU_SLL;
            F3_SRL: if (f7_base) alu_op = ALU_SRL;
            default: alu_op = ALU_NOP;
          endcase
        end
      end
      OPC_OP_IMM_32: begin
        use_imm = 1'b1;
        is_w    = 1'b1;
        if (SUPPORT_W) begin
          case (funct3)
            F3_ADD: alu_op = ALU_ADD;
            F3_SLL: if (f7_base) alu_op = ALU_SLL;
            F3_SRL: if (f7_base) alu_op = ALU_SRL;
            default: alu_op = ALU_NOP;
          endcase
        end
      end
      default: alu_op = ALU_NOP;
    endcase
  end

  assign illegal = (alu_op == ALU_NOP);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/writeback controller feeding a combinational 64-bit ALU and
// capturing its result for the register-file write port.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit SUPPORT_W = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  output logic [3:0]      Alu_opr,
  output logic [XLEN-1:0] IP_data1,
  output logic [XLEN-1:0] IP_data2,
  input  logic [XLEN-1:0] OP_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_illegal
);

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  logic [3:0]      dec_op;
  logic            dec_imm;
  logic            dec_w;
  logic            dec_illegal;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] opnd1;
  logic [XLEN-1:0] opnd2;
  logic            is_shift;

  logic            s1_valid;
  logic            s1_w;
  logic            s1_illegal;
  logic [4:0]      s1_rd;
  logic            wb_adv;
  logic            accept;

  alu_op_decode #(.SUPPORT_W(SUPPORT_W)) u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .alu_op  (dec_op),
    .use_imm (dec_imm),
    .is_w    (dec_w),
    .illegal (dec_illegal)
  );

  assign src2     = dec_imm ? imm : rs2_data;
  assign is_shift = (dec_op == ALU_SLL) || (dec_op == ALU_SRL);
  // Word right shifts must not pull upper-half bits into the low word
  assign opnd1    = ((dec_op == ALU_SRL) && dec_w) ? {{(XLEN-32){1'b0}}, rs1_data[31:0]}
                                                   : rs1_data;
  assign opnd2    = !is_shift ? src2
                  : dec_w     ? {{(XLEN-5){1'b0}}, src2[4:0]}
                              : {{(XLEN-6){1'b0}}, src2[5:0]};

  assign wb_adv   = !wb_valid || wb_ready;
  assign in_ready = !flush && (!s1_valid || wb_adv);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_w       <= 1'b0;
      s1_illegal <= 1'b0;
      s1_rd      <= '0;
      Alu_opr    <= ALU_NOP;
      IP_data1   <= '0;
      IP_data2   <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      wb_valid <= 1'b0;
    end else begin
      // issue stage
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_w       <= dec_w;
        s1_illegal <= dec_illegal;
        s1_rd      <= rd;
        Alu_opr    <= dec_op;
        IP_data1   <= opnd1;
        IP_data2   <= opnd2;
      end else if (wb_adv) begin
        s1_valid <= 1'b0;
      end
      // writeback stage
      if (wb_adv) begin
        wb_valid <= s1_valid;
        if (s1_valid) begin
          wb_data    <= s1_illegal ? '0 : (s1_w ? sext_w(OP_data[31:0]) : OP_data);
          wb_rd      <= s1_rd;
          wb_illegal <= s1_illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus randomized
// traffic scored against an ISA-level reference model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, wb_valid, wb_ready, wb_illegal;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [63:0] rs1_data, rs2_data, imm, IP_data1, IP_data2, OP_data, wb_data;
  logic [4:0]  rd, wb_rd;
  logic [3:0]  Alu_opr;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.XLEN(64), .SUPPORT_W(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .Alu_opr(Alu_opr), .IP_data1(IP_data1), .IP_data2(IP_data2), .OP_data(OP_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_illegal(wb_illegal)
  );

  // Stand-in ALU; unknown op codes return a marker so illegal zeroing is visible
  always_comb begin
    case (Alu_opr)
      ALU_ADD: OP_data = IP_data1 + IP_data2;
      ALU_SUB: OP_data = IP_data1 - IP_data2;
      ALU_SLL: OP_data = IP_data1 << IP_data2[5:0];
      ALU_XOR: OP_data = IP_data1 ^ IP_data2;
      ALU_SRL: OP_data = IP_data1 >> IP_data2[5:0];
      ALU_OR:  OP_data = IP_data1 | IP_data2;
      ALU_AND: OP_data = IP_data1 & IP_data2;
      default: OP_data = 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        ill;
    logic [3:0]  aop;
    logic [63:0] o1;
    logic [63:0] o2;
  } exp_t;

  exp_t q[$];

  // ISA-level semantics: result computed directly from the instruction meaning
  function automatic exp_t ref_exec(input logic [6:0] opc, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [63:0] a,
                                    input logic [63:0] b, input logic [63:0] im);
    exp_t e;
    logic is_r, is_i, w;
    logic [63:0] s2;
    int sh;
    is_r = (opc == 7'b0110011) || (opc == 7'b0111011);
    is_i = (opc == 7'b0010011) || (opc == 7'b0011011);
    w    = (opc == 7'b0111011) || (opc == 7'b0011011);
    s2   = is_i ? im : b;
    sh   = w ? int'(s2[4:0]) : int'(s2[5:0]);
    e.aop = 4'hF; e.o1 = a; e.o2 = s2; e.res = '0; e.rd = '0;
    if (is_r || is_i) begin
      case (f3)
        3'd0: begin
          if (is_i || f7 == 7'h00) begin e.aop = 4'd0; e.res = a + s2; end
          else if (f7 == 7'h20)   begin e.aop = 4'd1; e.res = a - s2; end
        end
        3'd1: if ((is_i && !w) ? (f7[6:1] == 6'd0) : (f7 == 7'h00)) begin
          e.aop = 4'd2; e.o2 = 64'(sh); e.res = a << sh;
        end
        3'd4: if (!w && (is_i || f7 == 7'h00)) begin e.aop = 4'd3; e.res = a ^ s2; end
        3'd5: if ((is_i && !w) ? (f7[6:1] == 6'd0) : (f7 == 7'h00)) begin
          e.aop = 4'd4; e.o2 = 64'(sh);
          if (w) begin e.o1 = {32'd0, a[31:0]}; e.res = {32'd0, a[31:0]} >> sh; end
          else   e.res = a >> sh;
        end
        3'd6: if (!w && (is_i || f7 == 7'h00)) begin e.aop = 4'd5; e.res = a | s2; end
        3'd7: if (!w && (is_i || f7 == 7'h00)) begin e.aop = 4'd6; e.res = a & s2; end
        default: e.aop = 4'hF;
      endcase
    end
    e.ill = (e.aop == 4'hF);
    if (e.ill)  e.res = '0;
    else if (w) e.res = {{32{e.res[31]}}, e.res[31:0]};
    return e;
  endfunction

  task automatic cycle(output logic acc);
    exp_t e, r;
    logic ret, held;
    logic [63:0] hd;
    @(negedge clk);
    acc  = in_valid && in_ready && !rst;
    ret  = wb_valid && wb_ready && !flush && !rst;
    held = wb_valid && !wb_ready && !flush && !rst;
    hd   = wb_data;
    if (ret) begin
      check("wb_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        r = q.pop_front();
        check("wb_data", wb_data, r.res);
        check("wb_rd", 64'(wb_rd), 64'(r.rd));
        check("wb_illegal", 64'(wb_illegal), 64'(r.ill));
      end
    end
    if (acc) begin
      e = ref_exec(opcode, funct3, funct7, rs1_data, rs2_data, imm);
      e.rd = rd;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst || flush) q.delete();
    else begin
      if (held) begin
        check("hold_valid", 64'(wb_valid), 64'd1);
        check("hold_data", wb_data, hd);
      end
      if (acc) begin
        check("alu_opr", 64'(Alu_opr), 64'(e.aop));
        if (!e.ill) begin
          check("ip_data1", IP_data1, e.o1);
          check("ip_data2", IP_data2, e.o2);
        end
      end
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                       input logic [4:0] d);
    opcode = opc; funct3 = f3; funct7 = f7;
    rs1_data = a; rs2_data = b; imm = im; rd = d; in_valid = 1'b1;
  endtask

  task automatic drain();
    logic a;
    in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle(a);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic one(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] im, input logic [3:0] eop, input logic [63:0] ewb);
    logic acc;
    wb_ready = 1'b1;
    drive(opc, f3, f7, a, b, im, 5'd7);
    cycle(acc);
    in_valid = 1'b0;
    check({tag, "_accept"}, 64'(acc), 64'd1);
    check({tag, "_op"}, 64'(Alu_opr), 64'(eop));
    check({tag, "_wb_early"}, 64'(wb_valid), 64'd0);
    cycle(acc);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, "_wb_data"}, wb_data, ewb);
  endtask

  task automatic fill2(input logic [63:0] base);
    logic acc;
    int n = 0;
    wb_ready = 1'b0;
    for (int c = 0; c < 6 && n < 2; c++) begin
      drive(OPC_OP, F3_ADD, F7_BASE, base + 64'(n), 64'd1, 64'd0, 5'(n + 1));
      cycle(acc);
      if (acc) n++;
    end
    check("fill2_accepts", 64'(n), 64'd2);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_alu_opr"}, 64'(Alu_opr), 64'hF);
    check({tag, "_ip1"}, IP_data1, 64'd0);
    check({tag, "_ip2"}, IP_data2, 64'd0);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_wb_data"}, wb_data, 64'd0);
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    check({tag, "_wb_illegal"}, 64'(wb_illegal), 64'd0);
  endtask

  initial begin
    logic acc;
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; rs1_data = '0; rs2_data = '0; imm = '0; rd = '0;
    repeat (2) cycle(acc);
    check_reset_values("reset");
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    one("add", OPC_OP, F3_ADD, F7_BASE, 64'd5, 64'd7, 64'd0, ALU_ADD, 64'd12);
    drain();
    one("subw", OPC_OP_32, F3_ADD, F7_SUB, 64'd0, 64'd1, 64'd0, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    one("sll", OPC_OP, F3_SLL, F7_BASE, 64'h3, 64'h41, 64'd0, ALU_SLL, 64'h6);
    check("sll_ip2", IP_data2, 64'd1);
    drain();
    one("slliw", OPC_OP_IMM_32, F3_SLL, F7_BASE, 64'd1, 64'd0, 64'd31, ALU_SLL,
        64'hFFFF_FFFF_8000_0000);
    drain();
    one("srlw", OPC_OP_32, F3_SRL, F7_BASE, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd0, ALU_SRL, 64'd1);
    check("srlw_ip1", IP_data1, 64'h8000_0000);
    drain();
    one("slt", OPC_OP, F3_SLT, F7_BASE, 64'd1, 64'd2, 64'd0, ALU_NOP, 64'd0);
    check("slt_illegal", 64'(wb_illegal), 64'd1);
    drain();

    // Back-to-back stream under backpressure
    wb_ready = 1'b0; n = 0;
    for (int c = 0; c < 3; c++) begin
      drive(OPC_OP, F3_ADD, F7_BASE, 64'(100 + n), 64'(n), 64'd0, 5'(n + 1));
      cycle(acc);
      if (acc) n++;
    end
    check("bp_accepts", 64'(n), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_hold_first", wb_data, 64'd100);
    wb_ready = 1'b1;
    for (int c = 0; c < 10 && n < 4; c++) begin
      drive(OPC_OP, F3_ADD, F7_BASE, 64'(100 + n), 64'(n), 64'd0, 5'(n + 1));
      cycle(acc);
      if (acc) n++;
    end
    check("bp_all_accepted", 64'(n), 64'd4);
    drain();
    repeat (3) cycle(acc);

    // Flush with both stages full and a pending input
    fill2(64'd200);
    drive(OPC_OP, F3_ADD, F7_BASE, 64'd99, 64'd1, 64'd0, 5'd9);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    cycle(acc);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_wb_valid", 64'(wb_valid), 64'd0);
    check("flush_s1_empty", 64'(in_ready), 64'd1);
    check("flush_no_load", IP_data1, 64'd201);
    check("flush_keep_wb_data", wb_data, 64'd201);
    cycle(acc);
    check("flush_stays_empty", 64'(wb_valid), 64'd0);

    // Reset wins over flush
    fill2(64'd300);
    drive(OPC_OP, F3_ADD, F7_BASE, 64'd77, 64'd1, 64'd0, 5'd9);
    flush = 1'b1; rst = 1'b1;
    cycle(acc);
    flush = 1'b0; rst = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_values("rst_flush");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int sel;
      logic [6:0] opc, f7;
      sel = int'($urandom_range(0, 9));
      case (sel % 4)
        0: opc = OPC_OP;
        1: opc = OPC_OP_IMM;
        2: opc = OPC_OP_32;
        default: opc = OPC_OP_IMM_32;
      endcase
      if (sel == 9) opc = 7'($urandom);
      case ($urandom_range(0, 3))
        0, 1: f7 = F7_BASE;
        2: f7 = F7_SUB;
        default: f7 = 7'($urandom);
      endcase
      drive(opc, 3'($urandom), f7, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 5'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      wb_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      cycle(acc);
    end
    rst = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Producer side of the 64-bit ALU interface.
- Accepts decoded RV64 integer-op fields and register/immediate operands through a valid/ready handshake.
- Translates the fields into the 4-bit ALU op code and registered operand pair, and captures the combinational ALU result into a writeback register.
- Two-stage pipeline (issue, writeback) sitting between the decoder and the register-file write port.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- SUPPORT_W, 1, when 1, OP-32/OP-IMM-32 (ADDW/SUBW/SLLW/SRLW and immediate forms) are legal; when 0 they flag illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  issue stage can accept.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- rs1_data  in  64  source 1 value.
- rs2_data  in  64  source 2 value.
- imm  in  64  sign-extended I-immediate.
- rd  in  5  destination register.
- Alu_opr  out  4  registered op code to ALU.
- IP_data1  out  64  registered ALU operand 1.
- IP_data2  out  64  registered ALU operand 2.
- OP_data  in  64  combinational ALU result.
- wb_valid  out  1  writeback entry valid.
- wb_ready  in  1  consumer accepts writeback.
- wb_data  out  64  final result.
- wb_rd  out  5  destination.
- wb_illegal  out  1  entry was unsupported.

Behaviour:
- Reset values: s1_valid=0, wb_valid=0, Alu_opr=4'b1111, IP_data1=IP_data2=0, wb_data=0, wb_rd=0, wb_illegal=0.
- Op code map:
  - ADD/ADDI/ADDW/ADDIW = 0000.
  - SUB/SUBW = 0001.
  - SLL/SLLI/SLLW/SLLIW = 0010.
  - XOR/XORI = 0011.
  - SRL/SRLI/SRLW/SRLIW = 0100.
  - OR/ORI = 0101.
  - AND/ANDI = 0110.
  - Anything else (SLT*, SRA*, other opcodes, bad funct7) = 1111, flagged illegal.
- Opcodes handled: OP 0110011, OP-IMM 0010011, OP-32 0111011, OP-IMM-32 0011011.
  - SUB requires funct7 0100000; all other R-forms require 0000000.
  - 64-bit immediate shifts require funct7[6:1]=000000.
- Operand rules:
  - IP_data1 = rs1_data, except SRLW/SRLIW, which use {32'b0, rs1_data[31:0]}.
  - IP_data2 = rs2_data for R-forms, imm for I-forms.
  - Shifts mask IP_data2 to 6 bits (64-bit forms) or 5 bits (W forms), zero-extended.
- Issue stage: accept when in_valid & in_ready at edge N. Alu_opr/IP_data1/IP_data2/s1_valid update at edge N. Operands hold their value while stalled or empty (no bubble zeroing).
- Writeback stage:
  - At edge N+1 (if wb slot free or consumed), wb_data captures OP_data.
  - W forms write {{32{OP_data[31]}}, OP_data[31:0]}.
  - Illegal entries write wb_data=0 with wb_illegal=1, and still flow through in order.
- Latency: 2 edges from accept to wb_valid. Throughput 1/cycle with wb_ready held high.
- Handshake:
  - wb_adv = !wb_valid | wb_ready.
  - in_ready = !flush & (!s1_valid | wb_adv).
  - wb_valid/wb_data hold stable while wb_valid & !wb_ready.
  - A held entry is never overwritten.
- Flush: at the edge, s1_valid=0 and wb_valid=0. A same-cycle input is not accepted because in_ready=0. Data registers keep their values.
- rst has priority over flush, mid-operation included: all state returns to reset values.
- Simultaneous wb_ready and s1 advance: old entry retires and new entry loads on the same edge.

Decomposition:
- alu_pkg holds:
  - ALU op code constants (ALU_ADD..ALU_AND, ALU_NOP=4'b1111).
  - RV opcode constants.
  - funct3 constants.
  - funct7 constants (F7_BASE, F7_SUB).
- One natural sub-module: alu_op_decode, a combinational function from opcode/funct3/funct7 to {op code, use_imm, is_w, illegal}.
- Pipeline registers stay in the top.

Test Plan:
- ADD, rs1=5, rs2=7, wb_ready=1 -> Alu_opr=0000 after edge N; wb_valid=1, wb_data=12 after edge N+1.
- SUBW, rs1=0, rs2=1 -> Alu_opr=0001; wb_data=64'hFFFF_FFFF_FFFF_FFFF.
- SLL with rs2=64'h41 -> IP_data2=1.
- SLLIW, rs1=1, imm=31 -> wb_data=64'hFFFF_FFFF_8000_0000.
- SRLW, rs1=64'hFFFF_FFFF_8000_0000, rs2=31 -> IP_data1=64'h8000_0000, wb_data=1.
- SLT (funct3 010) -> Alu_opr=1111, wb_illegal=1, wb_data=0.
- Back-to-back stream of 4 ADDs with wb_ready low for 3 cycles:
  - in_ready drops after 2 accepts.
  - wb_data holds the first result.
  - On release, all 4 results retire in order, none lost or duplicated.
- flush asserted with s1 and wb both full and in_valid=1:
  - Next cycle wb_valid=0, s1 empty, input not accepted.
  - Same sequence with rst also high: outputs at reset values.
